// File: rtl/pic_pkg.sv
// Shared constants for the PIC10F200 core: register map, STATUS bits, opcodes, ALU ops.
package pic_pkg;
  localparam logic [4:0] ADDR_INDF   = 5'h00;
  localparam logic [4:0] ADDR_TMR0   = 5'h01;
  localparam logic [4:0] ADDR_PCL    = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_FSR    = 5'h04;
  localparam logic [4:0] ADDR_OSCCAL = 5'h05;
  localparam logic [4:0] ADDR_GPIO   = 5'h06;

  localparam int ST_C  = 0;
  localparam int ST_DC = 1;
  localparam int ST_Z  = 2;
  localparam int ST_PD = 3;
  localparam int ST_TO = 4;

  localparam logic [5:0] OP_MISC   = 6'b000000;
  localparam logic [5:0] OP_SUBWF  = 6'b000010;
  localparam logic [5:0] OP_ADDWF  = 6'b000111;
  localparam logic [5:0] OP_DECFSZ = 6'b001011;
  localparam logic [5:0] OP_RRF    = 6'b001100;
  localparam logic [5:0] OP_RLF    = 6'b001101;
  localparam logic [5:0] OP_SWAPF  = 6'b001110;
  localparam logic [5:0] OP_INCFSZ = 6'b001111;

  localparam logic [3:0] OP_RETLW = 4'b1000;
  localparam logic [3:0] OP_CALL  = 4'b1001;
  localparam logic [3:0] OP_MOVLW = 4'b1100;
  localparam logic [3:0] OP_IORLW = 4'b1101;
  localparam logic [3:0] OP_ANDLW = 4'b1110;
  localparam logic [3:0] OP_XORLW = 4'b1111;

  typedef enum logic [3:0] {
    ALU_MOVA, ALU_MOVB, ALU_ADD, ALU_SUB, ALU_AND, ALU_IOR, ALU_XOR,
    ALU_COM, ALU_INC, ALU_DEC, ALU_RRF, ALU_RLF, ALU_SWAP, ALU_CLR
  } alu_op_e;

  // ALU operation implied by an instruction word; non-ALU words fall back to MOVA.
  function automatic alu_op_e alu_sel(input logic [11:0] ins);
    alu_op_e op;
    op = ALU_MOVA;
    case (ins[11:6])
      OP_MISC:   op = ALU_MOVB;
      6'b000001: op = ALU_CLR;
      OP_SUBWF:  op = ALU_SUB;
      6'b000011: op = ALU_DEC;
      6'b000100: op = ALU_IOR;
      6'b000101: op = ALU_AND;
      6'b000110: op = ALU_XOR;
      OP_ADDWF:  op = ALU_ADD;
      6'b001000: op = ALU_MOVA;
      6'b001001: op = ALU_COM;
      6'b001010: op = ALU_INC;
      OP_DECFSZ: op = ALU_DEC;
      OP_RRF:    op = ALU_RRF;
      OP_RLF:    op = ALU_RLF;
      OP_SWAPF:  op = ALU_SWAP;
      OP_INCFSZ: op = ALU_INC;
      default: begin
        case (ins[11:8])
          OP_IORLW: op = ALU_IOR;
          OP_ANDLW: op = ALU_AND;
          OP_XORLW: op = ALU_XOR;
          default:  op = ALU_MOVA;
        endcase
      end
    endcase
    return op;
  endfunction
endpackage

// File: rtl/pic_alu.sv
// 8-bit ALU for the PIC core; a is the file/literal operand, b is W.
module pic_alu
  import pic_pkg::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] result,
  output logic       c,
  output logic       dc,
  output logic       z
);
  logic [8:0] sum;
  logic [4:0] nib;

  always_comb begin
    sum    = '0;
    nib    = '0;
    result = a;
    c      = c_in;
    dc     = 1'b0;
    case (op)
      ALU_MOVA: result = a;
      ALU_MOVB: result = b;
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        nib    = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        result = sum[7:0];
        c      = sum[8];
        dc     = nib[4];
      end
      // a - b as a + ~b + 1, so carry-out is the no-borrow flag
      ALU_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + 9'd1;
        nib    = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + 5'd1;
        result = sum[7:0];
        c      = sum[8];
        dc     = nib[4];
      end
      ALU_AND:  result = a & b;
      ALU_IOR:  result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_COM:  result = ~a;
      ALU_INC:  result = a + 8'd1;
      ALU_DEC:  result = a - 8'd1;
      ALU_RRF: begin
        result = {c_in, a[7:1]};
        c      = a[0];
      end
      ALU_RLF: begin
        result = {a[6:0], c_in};
        c      = a[7];
      end
      ALU_SWAP: result = {a[3:0], a[7:4]};
      ALU_CLR:  result = 8'h00;
      default:  result = a;
    endcase
    z = (result == 8'h00);
  end
endmodule

// File: rtl/procesador_pic10f200.sv
// Single-cycle PIC10F200-compatible core: ROM, W, SFR/GPR file, 2-level stack, PC sequencing.
module procesador_pic10f200
  import pic_pkg::*;
#(
  parameter string PROG_FILE = "program.hex",
  parameter int    ROM_DEPTH = 512
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] gpio_o,
  output logic [8:0] pc_o
);
  logic [11:0] rom [ROM_DEPTH];

  logic [8:0] pc_q, pc_d, stk0_q, stk0_d, stk1_q, stk1_d;
  logic [7:0] w_q, w_d, tmr0_q, tmr0_d, osccal_q, osccal_d, option_q, option_d;
  logic [4:0] status_q, status_d, fsr_q, fsr_d;
  logic [3:0] gpio_q, gpio_d, tris_q, tris_d;
  logic       skip_q, skip_d, halt_q, halt_d;
  logic [7:0] gpr_q [16];

  logic [11:0] instr;
  logic [4:0]  ea;
  logic [7:0]  fval, alu_a, alu_res, wdata, bit_res;
  logic        alu_c, alu_dc, alu_z;
  logic        wr_res, wr_f, gpr_we, upd_z, upd_c, upd_dc;
  alu_op_e     alu_op;

  assign gpio_o = gpio_q;
  assign pc_o   = pc_q;

  // Operand fetch: INDF redirects through FSR; FSR=0 makes INDF read as zero.
  always_comb begin
    instr = rom[pc_q];
    ea    = (instr[4:0] == ADDR_INDF) ? fsr_q : instr[4:0];
    case (ea)
      ADDR_INDF:   fval = 8'h00;
      ADDR_TMR0:   fval = tmr0_q;
      ADDR_PCL:    fval = pc_q[7:0];
      ADDR_STATUS: fval = {3'b000, status_q};
      ADDR_FSR:    fval = {3'b111, fsr_q};
      ADDR_OSCCAL: fval = osccal_q;
      ADDR_GPIO:   fval = {4'h0, gpio_q};
      default:     fval = ea[4] ? gpr_q[ea[3:0]] : 8'h00;
    endcase
    alu_op = alu_sel(instr);
    alu_a  = instr[11] ? instr[7:0] : fval;
  end

  pic_alu u_alu (
    .op(alu_op), .a(alu_a), .b(w_q), .c_in(status_q[ST_C]),
    .result(alu_res), .c(alu_c), .dc(alu_dc), .z(alu_z)
  );

  always_comb begin
    pc_d = pc_q + 9'd1;  w_d = w_q;  status_d = status_q;  fsr_d = fsr_q;
    gpio_d = gpio_q;  tmr0_d = tmr0_q;  osccal_d = osccal_q;  option_d = option_q;
    tris_d = tris_q;  stk0_d = stk0_q;  stk1_d = stk1_q;  skip_d = 1'b0;  halt_d = halt_q;
    wdata = alu_res;  wr_res = 1'b0;  wr_f = 1'b0;  gpr_we = 1'b0;
    upd_z = 1'b0;  upd_c = 1'b0;  upd_dc = 1'b0;
    bit_res = fval;
    bit_res[instr[7:5]] = instr[8];

    if (halt_q) begin
      pc_d = pc_q;
    end else if (!skip_q) begin
      if (instr[11:10] == 2'b00) begin
        case (instr[11:6])
          OP_MISC: begin
            if (instr[5]) wr_f = 1'b1;
            else begin
              case (instr[4:0])
                5'h02: option_d = w_q;
                5'h03: begin
                  status_d[ST_PD] = 1'b0;  status_d[ST_TO] = 1'b1;
                  halt_d = 1'b1;  pc_d = pc_q;
                end
                5'h04: begin status_d[ST_PD] = 1'b1;  status_d[ST_TO] = 1'b1; end
                5'h06: tris_d = w_q[3:0];
                default: ;
              endcase
            end
          end
          OP_SUBWF, OP_ADDWF: begin wr_res = 1'b1; upd_z = 1'b1; upd_c = 1'b1; upd_dc = 1'b1; end
          OP_RRF, OP_RLF:     begin wr_res = 1'b1; upd_c = 1'b1; end
          OP_SWAPF:           wr_res = 1'b1;
          OP_DECFSZ, OP_INCFSZ: begin wr_res = 1'b1; skip_d = (alu_res == 8'h00); end
          default:            begin wr_res = 1'b1; upd_z = 1'b1; end
        endcase
      end else if (instr[11:10] == 2'b01) begin
        case (instr[9:8])
          2'b10:   skip_d = ~fval[instr[7:5]];
          2'b11:   skip_d = fval[instr[7:5]];
          default: begin wdata = bit_res; wr_f = 1'b1; end
        endcase
      end else begin
        case (instr[11:8])
          OP_RETLW: begin w_d = instr[7:0]; pc_d = stk0_q; stk0_d = stk1_q; end
          OP_CALL: begin
            stk1_d = stk0_q;  stk0_d = pc_q + 9'd1;  pc_d = {1'b0, instr[7:0]};
          end
          4'b1010, 4'b1011: pc_d = instr[8:0];
          OP_MOVLW: w_d = instr[7:0];
          default:  begin w_d = alu_res; upd_z = 1'b1; end
        endcase
      end
    end

    if (wr_res) begin
      if (instr[5]) wr_f = 1'b1;
      else          w_d  = alu_res;
    end
    if (wr_f) begin
      case (ea)
        ADDR_INDF:   ;
        ADDR_TMR0:   tmr0_d = wdata;
        ADDR_PCL:    pc_d = {1'b0, wdata};
        ADDR_STATUS: status_d[2:0] = wdata[2:0];
        ADDR_FSR:    fsr_d = wdata[4:0];
        ADDR_OSCCAL: osccal_d = wdata;
        ADDR_GPIO:   gpio_d = wdata[3:0];
        default:     gpr_we = ea[4];
      endcase
    end
    // Flag updates land after the STATUS write so they win on the same bits.
    if (upd_z)  status_d[ST_Z]  = alu_z;
    if (upd_c)  status_d[ST_C]  = alu_c;
    if (upd_dc) status_d[ST_DC] = alu_dc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;  w_q <= '0;  status_q <= 5'h18;  fsr_q <= '0;  gpio_q <= '0;
      tmr0_q <= '0;  osccal_q <= '0;  option_q <= 8'hFF;  tris_q <= 4'hF;
      stk0_q <= '0;  stk1_q <= '0;  skip_q <= 1'b0;  halt_q <= 1'b0;
      for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
    end else begin
      pc_q <= pc_d;  w_q <= w_d;  status_q <= status_d;  fsr_q <= fsr_d;  gpio_q <= gpio_d;
      tmr0_q <= tmr0_d;  osccal_q <= osccal_d;  option_q <= option_d;  tris_q <= tris_d;
      stk0_q <= stk0_d;  stk1_q <= stk1_d;  skip_q <= skip_d;  halt_q <= halt_d;
      if (gpr_we) gpr_q[ea[3:0]] <= wdata;
    end
  end
endmodule

// File: tb/tb_procesador_pic10f200.sv
// Directed-program bench for the PIC10F200 core; ROM is filled hierarchically per test.
module tb_procesador_pic10f200;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gpio_o;
  logic [8:0] pc_o;
  int nvec = 0;
  int nerr = 0;

  procesador_pic10f200 #(.PROG_FILE(""), .ROM_DEPTH(512)) dut (
    .clk(clk), .rst(rst), .gpio_o(gpio_o), .pc_o(pc_o)
  );

  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input logic [11:0] w);
    dut.rom[a] = w;
  endtask

  task automatic wipe();
    rst = 1'b1;
    for (int i = 0; i < 512; i++) dut.rom[i] = 12'h000;
  endtask

  task automatic boot();
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    // T1/T2: reset state, then MOVLW 0F; MOVWF 10; MOVLW F1; ADDWF 10,1
    wipe();
    put(0, 12'hC0F); put(1, 12'h030); put(2, 12'hCF1); put(3, 12'h1F0);
    step(1);
    chk("rst_pc", pc_o, 0);
    chk("rst_w", dut.w_q, 0);
    chk("rst_status", dut.status_q, 8'h18);
    chk("rst_gpio", gpio_o, 0);
    rst = 1'b0;
    step(1);
    chk("t1_pc", pc_o, 1);
    chk("t1_w", dut.w_q, 8'h0F);
    step(3);
    chk("t2_reg10", dut.gpr_q[0], 8'h00);
    chk("t2_status", dut.status_q, 8'h1F);
    chk("t2_w", dut.w_q, 8'hF1);
    chk("t2_pc", pc_o, 4);

    // T3: CALL 05 / RETLW 42
    wipe();
    put(0, 12'h905); put(5, 12'h842);
    boot();
    chk("t3_pc0", pc_o, 0);
    step(1);
    chk("t3_pc5", pc_o, 5);
    chk("t3_stk0", dut.stk0_q, 1);
    step(1);
    chk("t3_pc1", pc_o, 1);
    chk("t3_w", dut.w_q, 8'h42);

    // T4: DECFSZ loop
    wipe();
    put(0, 12'hC02); put(1, 12'h031); put(2, 12'h2F1); put(3, 12'hA02); put(4, 12'hCAA);
    boot();
    step(2);
    chk("t4_r11_init", dut.gpr_q[1], 2);
    step(1);
    chk("t4_r11_1", dut.gpr_q[1], 1);
    chk("t4_pc_goto", pc_o, 3);
    step(1);
    chk("t4_pc_loop", pc_o, 2);
    step(1);
    chk("t4_r11_0", dut.gpr_q[1], 0);
    chk("t4_skip", dut.skip_q, 1);
    step(1);
    chk("t4_pc_nop", pc_o, 4);
    chk("t4_w_nop", dut.w_q, 2);
    step(1);
    chk("t4_w", dut.w_q, 8'hAA);

    // T5: INCFSZ on 0xFF wraps, nulls next word, leaves Z alone
    wipe();
    put(0, 12'hCFF); put(1, 12'h030); put(2, 12'h3F0); put(3, 12'hC33); put(4, 12'hC44);
    boot();
    step(3);
    chk("t5_reg10", dut.gpr_q[0], 0);
    chk("t5_status", dut.status_q, 8'h18);
    step(1);
    chk("t5_w_nulled", dut.w_q, 8'hFF);
    step(1);
    chk("t5_w", dut.w_q, 8'h44);

    // T6: indirect write, GPIO, BSF, FSR readback
    wipe();
    put(0, 12'hC12); put(1, 12'h024); put(2, 12'hC5A); put(3, 12'h020);
    put(4, 12'hC0A); put(5, 12'h026); put(6, 12'h506); put(7, 12'h204);
    boot();
    step(4);
    chk("t6_reg12", dut.gpr_q[2], 8'h5A);
    step(2);
    chk("t6_gpio_a", gpio_o, 4'hA);
    step(1);
    chk("t6_gpio_b", gpio_o, 4'hB);
    step(1);
    chk("t6_fsr_rd", dut.w_q, 8'hF2);
    rst = 1'b1;
    step(1);
    chk("t6_rst_gpio", gpio_o, 0);
    chk("t6_rst_reg12", dut.gpr_q[2], 0);
    chk("t6_rst_pc", pc_o, 0);

    // T7: SUBWF flags, RLF through C, PCL read
    wipe();
    put(0, 12'hC05); put(1, 12'h030); put(2, 12'hC03); put(3, 12'h090);
    put(4, 12'h370); put(5, 12'h202);
    boot();
    step(4);
    chk("t7_sub_w", dut.w_q, 8'h02);
    chk("t7_sub_status", dut.status_q, 8'h1B);
    step(1);
    chk("t7_rlf_r10", dut.gpr_q[0], 8'h0B);
    chk("t7_rlf_status", dut.status_q, 8'h1A);
    step(1);
    chk("t7_pcl_rd", dut.w_q, 8'h05);

    // T8: SLEEP freezes PC and clears PD
    wipe();
    put(0, 12'h003); put(1, 12'hC77);
    boot();
    step(1);
    chk("t8_status", dut.status_q, 8'h10);
    step(3);
    chk("t8_pc", pc_o, 0);
    chk("t8_w", dut.w_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
